// File: rtl/axi_stream_output.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_output
// Purpose  : Transmit side of the accelerator AXI4-Stream link. Latches one
//            completed result vector of N characters from the compute core and
//            serialises it onto an AXI4-Stream master port as N beats, with
//            TLAST on the final beat, toward the PS/DMA S2MM channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N          characters (beats) per packet, N >= 2
//   CHAR_LEN   bits per character, equals TDATA width
// Ports
//   ACLK           in   1           clock, rising edge
//   ARESETN        in   1           asynchronous active-low reset
//   M_AXIS_TDATA   out  CHAR_LEN    current character (registered)
//   M_AXIS_TLAST   out  1           high on beat N-1 only (registered)
//   M_AXIS_TVALID  out  1           beat valid (registered)
//   M_AXIS_TREADY  in   1           downstream ready
//   valid          in   1           result vector d offered this cycle
//   d              in   N*CHAR_LEN  result vector, element i at d[i*CHAR_LEN +: CHAR_LEN]
//   ready          out  1           block accepts valid this cycle
//   done           out  1           one-cycle pulse after the final beat handshake
// Build option
//   AXIS_OUT_BACK2BACK_EN  when defined, adds a one-deep pending vector buffer
//                          so consecutive packets are sent without a bubble.
//                          When undefined, ready is high only in IDLE and at
//                          least one TVALID=0 cycle separates packets.
// ============================================================================
module axi_stream_output #(
  parameter int N        = 4,
  parameter int CHAR_LEN = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  input  logic                  valid,
  input  logic [N*CHAR_LEN-1:0] d,
  output logic                  ready,
  output logic                  done
);

  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BUF_W  = N * CHAR_LEN;
  // Element 0 lives in the TDATA register itself, so the active buffer only
  // has to hold the remaining N-1 elements.
  localparam int REST_W = (N - 1) * CHAR_LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [REST_W-1:0]   rest_q,  rest_d;   // elements not yet in TDATA, next one in the low bits
  logic [CNT_W-1:0]    cnt_q,   cnt_d;    // index of the beat currently on TDATA
  logic [CHAR_LEN-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q,  tlast_d;
  logic                done_q,   done_d;

  logic                beat_hs;           // TVALID && TREADY at this edge
  logic                last_hs;           // handshake of beat N-1
  logic                load_en;           // start a new packet from load_vec
  logic [BUF_W-1:0]    load_vec;
  logic [CNT_W-1:0]    cnt_inc;

`ifdef AXIS_OUT_BACK2BACK_EN
  logic [BUF_W-1:0]    pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
`endif

  assign beat_hs = tvalid_q && M_AXIS_TREADY;
  assign last_hs = beat_hs && (cnt_q == LAST_CNT);
  assign cnt_inc = cnt_q + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rest_d   = rest_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_vec = d;
`ifdef AXIS_OUT_BACK2BACK_EN
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // ready is 1 in IDLE, so valid alone is the accept condition.
        if (valid) begin
          load_en = 1'b1;
        end
      end

      ST_SEND: begin
        if (last_hs) begin
          done_d = 1'b1;
`ifdef AXIS_OUT_BACK2BACK_EN
          if (pend_full_q) begin
            // Queued vector becomes the active packet with no bubble.
            load_en     = 1'b1;
            load_vec    = pend_q;
            pend_full_d = 1'b0;
          end else if (valid) begin
            // Pending slot is empty, so ready is high; a vector arriving on
            // the last handshake goes straight into the active path, which is
            // indistinguishable from passing through the pending slot.
            load_en = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
`else
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
`endif
        end else if (beat_hs) begin
          // Advance to the next element; TDATA is always a register output,
          // so TREADY never reaches TDATA combinationally.
          cnt_d   = cnt_inc;
          tdata_d = rest_q[CHAR_LEN-1:0];
          rest_d  = rest_q >> CHAR_LEN;
          tlast_d = (cnt_inc == LAST_CNT);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

`ifdef AXIS_OUT_BACK2BACK_EN
    // Capture into the pending slot while a packet is in flight, unless the
    // vector was already consumed directly on the last handshake above.
    if ((state_q == ST_SEND) && valid && !pend_full_q && !last_hs) begin
      pend_d      = d;
      pend_full_d = 1'b1;
    end
`endif

    if (load_en) begin
      state_d  = ST_SEND;
      tdata_d  = load_vec[CHAR_LEN-1:0];
      rest_d   = load_vec[BUF_W-1:CHAR_LEN];
      cnt_d    = '0;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;                     // N >= 2, so beat 0 is never last
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      rest_q   <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef AXIS_OUT_BACK2BACK_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rest_q   <= rest_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
`ifdef AXIS_OUT_BACK2BACK_EN
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
`endif
    end
  end

  // ready is derived from registered state only.
`ifdef AXIS_OUT_BACK2BACK_EN
  assign ready = (state_q == ST_IDLE) || !pend_full_q;
`else
  assign ready = (state_q == ST_IDLE);
`endif

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign done          = done_q;

endmodule
`default_nettype wire
